quiz_round_controller: RTL and testbench
========================================

Name: quiz_round_controller

Overview:
Sequencing and arbitration controller for the two-player quiz game. It debounces and decodes the shared 8-bit active-low joystick bus and arbitrates first press between player 1 and player 2. It judges the press against the current question's answer, then drives question index, scores, lockouts, result display and the end-of-game beep. It replaces the unclocked, level-triggered question stepping and score counting with a single clocked FSM.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a full release (min 1).
RESULT_CYCLES, 25000000, cycles the judged result is held before the FSM moves on (min 1).
NUM_QUESTIONS, 10, question count; q_index wraps modulo this value.
WIN_SCORE, 5, score that ends the game (max 7).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous and active-low.
joy_n  in  8  raw joystick bus, active-low, asynchronous to clk. Bits 7..4 are P1 choices 1..4; bits 3..0 are P2 choices 1..4 (bit7/bit3 = choice 1).
ans  in  3  correct choice for q_index (1..4). Any other value means every press is judged wrong.
restart  in  1  synchronous game restart, active-high.
q_index  out  4  current question, 0..NUM_QUESTIONS-1.
score_p1  out  3  P1 score.
score_p2  out  3  P2 score.
lock_p1  out  1  P1 locked out for the current question.
lock_p2  out  1  P2 locked out for the current question.
result  out  2  00 none, 01 correct, 10 wrong. Valid in SHOW only; 00 elsewhere.
result_player  out  2  01 P1, 10 P2, 00 none.
game_over  out  1  a player has reached WIN_SCORE.
beep  out  1  buzzer drive; equals game_over.

Behaviour:
- Reset (rst_n low, asynchronous): state ARM, q_index 0, scores 0, locks 0, result 00, result_player 00, game_over 0, beep 0, round-robin priority set to P1, counters 0.
- joy_n passes through a 2-flop synchronizer. All latencies below count from the synchronized value (sync latency 2 cycles).
- Masked pattern: the synced bus with the nibble of any locked player forced to 1111.
- Per-player valid: the player's nibble of the masked pattern has exactly one zero bit. Nibbles with 2+ zero bits count as invalid (no press).
- Stability counter: cleared whenever the masked pattern differs from the previous cycle; otherwise increments, saturating.
- ARM: wait for the masked pattern to equal 8'hFF for DEBOUNCE_CYCLES consecutive cycles, then go to WAIT.
- WAIT: when the masked pattern has been stable for DEBOUNCE_CYCLES cycles and at least one player is valid, go to JUDGE.
- JUDGE (1 cycle):
  - One valid player: that player is selected.
  - Both valid: the player holding round-robin priority is selected, and priority passes to the other player.
  - If the choice equals ans: that player's score increments and result becomes 01.
  - Otherwise: that player's lock is set and result becomes 10.
  - result_player is set to the selected player. Go to SHOW.
- SHOW: hold result and result_player for exactly RESULT_CYCLES cycles, then take the first matching transition:
  - either score equals WIN_SCORE -> OVER;
  - result 01, or both locks set -> NEXT;
  - otherwise -> ARM (same question; the remaining player may still answer).
- NEXT (1 cycle): q_index advances (NUM_QUESTIONS-1 wraps to 0), locks clear, result and result_player go to 00, go to ARM.
- OVER: game_over=1 and beep=1. Scores and q_index are frozen, joy_n is ignored, and the FSM stays here until restart.
- restart: honoured in every state. At the next edge it applies all reset values except round-robin priority, which is kept. restart takes precedence over every other transition in that cycle.
- Scores never exceed WIN_SCORE. Only one score can change per JUDGE.
- ans is sampled only in JUDGE, so a change to ans in other states has no effect.

Test Plan:
(All with DEBOUNCE_CYCLES=4, RESULT_CYCLES=8, NUM_QUESTIONS=10, WIN_SCORE=5.)
- Reset with joy_n=FF, ans=1, then drive joy_n=7F for 10 cycles -> JUDGE fires; score_p1=1; result=01 and result_player=01 for 8 cycles; q_index=1.
- ans=2, P2 presses 8'hF7 (choice 1) -> result=10, lock_p2=1, q_index stays 0. Further P2 presses are ignored. P1 presses 8'hBF -> score_p1=1, lock_p2 clears, q_index=1.
- Both players press correctly in the same cycle (8'h77, ans=1), twice -> first P1 scores, second P2 scores (round-robin alternates).
- Press glitch: 8'h7F held only 3 cycles then FF -> no JUDGE. P1 presses 8'h3F (two bits low) -> ignored. Both players answer wrong -> q_index advances, scores unchanged.
- P1 answers correctly 5 times -> game_over=1 and beep=1 after the 5th SHOW; later presses leave state unchanged. A restart pulse -> scores 0, q_index 0, game_over 0.
- q_index at 9 with a correct answer -> q_index wraps to 0. rst_n low in the middle of SHOW -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/quiz_round_controller_if.sv
// Joystick, answer and restart inputs plus all game-state outputs of the quiz round controller.
interface quiz_round_controller_if;
    logic [7:0] joy_n;
    logic [2:0] ans;
    logic       restart;
    logic [3:0] q_index;
    logic [2:0] score_p1;
    logic [2:0] score_p2;
    logic       lock_p1;
    logic       lock_p2;
    logic [1:0] result;
    logic [1:0] result_player;
    logic       game_over;
    logic       beep;

    modport master (
        output joy_n, ans, restart,
        input  q_index, score_p1, score_p2, lock_p1, lock_p2, result, result_player,
               game_over, beep
    );

    modport slave (
        input  joy_n, ans, restart,
        output q_index, score_p1, score_p2, lock_p1, lock_p2, result, result_player,
               game_over, beep
    );
endinterface

// File: rtl/quiz_round_controller.sv
// Two-player quiz sequencer: debounces the shared active-low joystick bus, arbitrates first
// press with round-robin tie-break, judges against ans and tracks question, scores and locks.
module quiz_round_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned RESULT_CYCLES   = 25000000,
    parameter int unsigned NUM_QUESTIONS   = 10,
    parameter int unsigned WIN_SCORE       = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    quiz_round_controller_if.slave bus
);
    localparam int unsigned StabW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ShowW = $clog2(RESULT_CYCLES + 1);
    localparam logic [StabW-1:0] StabMax  = StabW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ShowW-1:0] ShowLast = ShowW'(RESULT_CYCLES - 1);
    localparam logic [3:0]       QLast    = 4'(NUM_QUESTIONS - 1);
    localparam logic [2:0]       Win      = 3'(WIN_SCORE);

    typedef enum logic [2:0] {StArm, StWait, StJudge, StShow, StNext, StOver} state_e;

    function automatic logic one_zero(input logic [3:0] n);
        return (n == 4'b0111) || (n == 4'b1011) || (n == 4'b1101) || (n == 4'b1110);
    endfunction

    function automatic logic [2:0] choice_of(input logic [3:0] n);
        case (n)
            4'b0111: return 3'd1;
            4'b1011: return 3'd2;
            4'b1101: return 3'd3;
            4'b1110: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       sync1_q, sync2_q, prev_q, press_q, press_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [ShowW-1:0] show_q, show_d;
    logic [3:0]       q_q, q_d;
    logic [2:0]       s1_q, s1_d, s2_q, s2_d;
    logic             l1_q, l1_d, l2_q, l2_d;
    logic [1:0]       res_q, res_d, rp_q, rp_d;
    logic             prio_q, prio_d;

    logic [7:0] masked;
    logic       stable, v1, v2, j1, j2, sel_p2, correct;
    logic [2:0] ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StArm;
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
            prev_q  <= 8'hFF;
            press_q <= 8'hFF;
            stab_q  <= '0;
            show_q  <= '0;
            q_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
            res_q   <= 2'b00;
            rp_q    <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= bus.joy_n;
            sync2_q <= sync1_q;
            prev_q  <= masked;
            press_q <= press_d;
            stab_q  <= stab_d;
            show_q  <= show_d;
            q_q     <= q_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            res_q   <= res_d;
            rp_q    <= rp_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        masked = sync2_q | {{4{l1_q}}, {4{l2_q}}};
        v1     = one_zero(masked[7:4]);
        v2     = one_zero(masked[3:0]);
        // stab_d counts how long the current pattern has been present, minus one
        if (masked != prev_q)      stab_d = '0;
        else if (stab_q < StabMax) stab_d = stab_q + 1'b1;
        else                       stab_d = stab_q;
        stable = (stab_d == StabMax);

        j1      = one_zero(press_q[7:4]);
        j2      = one_zero(press_q[3:0]);
        sel_p2  = j2 && (!j1 || prio_q);
        ch      = sel_p2 ? choice_of(press_q[3:0]) : choice_of(press_q[7:4]);
        correct = (ch == bus.ans);

        state_d = state_q;
        press_d = press_q;
        show_d  = show_q;
        q_d     = q_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        res_d   = res_q;
        rp_d    = rp_q;
        prio_d  = prio_q;

        unique case (state_q)
            StArm: if (stable && masked == 8'hFF) state_d = StWait;
            StWait: begin
                if (stable && (v1 || v2)) begin
                    press_d = masked;
                    state_d = StJudge;
                end
            end
            StJudge: begin
                if (j1 && j2) prio_d = ~prio_q;
                rp_d = sel_p2 ? 2'b10 : 2'b01;
                if (correct) begin
                    res_d = 2'b01;
                    if (sel_p2 && s2_q < Win)       s2_d = s2_q + 1'b1;
                    else if (!sel_p2 && s1_q < Win) s1_d = s1_q + 1'b1;
                end else begin
                    res_d = 2'b10;
                    if (sel_p2) l2_d = 1'b1;
                    else        l1_d = 1'b1;
                end
                show_d  = '0;
                state_d = StShow;
            end
            StShow: begin
                if (show_q == ShowLast) begin
                    show_d = '0;
                    res_d  = 2'b00;
                    rp_d   = 2'b00;
                    if (s1_q == Win || s2_q == Win)          state_d = StOver;
                    else if (res_q == 2'b01 || (l1_q && l2_q)) state_d = StNext;
                    else                                       state_d = StArm;
                end else begin
                    show_d = show_q + 1'b1;
                end
            end
            StNext: begin
                q_d     = (q_q == QLast) ? 4'd0 : q_q + 4'd1;
                l1_d    = 1'b0;
                l2_d    = 1'b0;
                res_d   = 2'b00;
                rp_d    = 2'b00;
                state_d = StArm;
            end
            StOver: state_d = StOver;
            default: state_d = StArm;
        endcase

        // Restart wins over everything but keeps the tie-break owner
        if (bus.restart) begin
            state_d = StArm;
            press_d = 8'hFF;
            stab_d  = '0;
            show_d  = '0;
            q_d     = '0;
            s1_d    = '0;
            s2_d    = '0;
            l1_d    = 1'b0;
            l2_d    = 1'b0;
            res_d   = 2'b00;
            rp_d    = 2'b00;
        end
    end

    assign bus.q_index       = q_q;
    assign bus.score_p1      = s1_q;
    assign bus.score_p2      = s2_q;
    assign bus.lock_p1       = l1_q;
    assign bus.lock_p2       = l2_q;
    assign bus.result        = res_q;
    assign bus.result_player = rp_q;
    assign bus.game_over     = (state_q == StOver);
    assign bus.beep          = (state_q == StOver);
endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller with short debounce/result timing.
module tb_quiz_round_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [1:0] last_res, last_rp;
    int   show_len;

    quiz_round_controller_if bus ();

    quiz_round_controller #(
        .DEBOUNCE_CYCLES(4),
        .RESULT_CYCLES  (8),
        .NUM_QUESTIONS  (10),
        .WIN_SCORE      (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.joy_n   = 8'hFF;
        bus.restart = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Drive a press until SHOW is seen, release, and measure how long the result is held.
    task automatic do_press(input string tag, input logic [7:0] pat);
        bit found = 0;
        bus.joy_n = pat;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.result != 2'b00) found = 1;
        end
        check_val({tag, "_seen"}, 32'(found), 32'd1);
        last_res  = bus.result;
        last_rp   = bus.result_player;
        bus.joy_n = 8'hFF;
        show_len  = 0;
        while (found && bus.result != 2'b00 && show_len < 40) begin
            show_len++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    // Hold a pattern and count cycles in which any result appears.
    task automatic hold_quiet(input string tag, input logic [7:0] pat, input int cycles);
        int hits = 0;
        bus.joy_n = pat;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.result != 2'b00) hits++;
        end
        bus.joy_n = 8'hFF;
        repeat (8) @(negedge clk);
        check_val({tag, "_no_judge"}, 32'(hits), 32'd0);
    endtask

    initial begin
        bus.joy_n   = 8'hFF;
        bus.ans     = 3'd1;
        bus.restart = 1'b0;
        do_reset();

        // Reset state and a basic correct P1 answer
        check_val("rst_q", 32'(bus.q_index), 0);
        check_val("rst_s1", 32'(bus.score_p1), 0);
        check_val("rst_s2", 32'(bus.score_p2), 0);
        check_val("rst_locks", 32'({bus.lock_p1, bus.lock_p2}), 0);
        check_val("rst_res", 32'({bus.result, bus.result_player}), 0);
        check_val("rst_over", 32'({bus.game_over, bus.beep}), 0);
        do_press("t1", 8'h7F);
        check_val("t1_res", 32'(last_res), 1);
        check_val("t1_rp", 32'(last_rp), 1);
        check_val("t1_len", 32'(show_len), 8);
        check_val("t1_s1", 32'(bus.score_p1), 1);
        check_val("t1_q", 32'(bus.q_index), 1);

        // P2 wrong then locked out; P1 correct clears lock and advances
        do_reset();
        bus.ans = 3'd2;
        do_press("t2a", 8'hF7);
        check_val("t2a_res", 32'(last_res), 2);
        check_val("t2a_rp", 32'(last_rp), 2);
        check_val("t2a_lock", 32'({bus.lock_p1, bus.lock_p2}), 1);
        check_val("t2a_q", 32'(bus.q_index), 0);
        hold_quiet("t2_locked", 8'hF7, 20);
        do_press("t2b", 8'hBF);
        check_val("t2b_res", 32'(last_res), 1);
        check_val("t2b_rp", 32'(last_rp), 1);
        check_val("t2b_s1", 32'(bus.score_p1), 1);
        check_val("t2b_lock", 32'({bus.lock_p1, bus.lock_p2}), 0);
        check_val("t2b_q", 32'(bus.q_index), 1);

        // Simultaneous correct presses alternate winner
        do_reset();
        bus.ans = 3'd1;
        do_press("t3a", 8'h77);
        check_val("t3a_rp", 32'(last_rp), 1);
        check_val("t3a_s", 32'({bus.score_p1, bus.score_p2}), 32'h08);
        do_press("t3b", 8'h77);
        check_val("t3b_rp", 32'(last_rp), 2);
        check_val("t3b_s", 32'({bus.score_p1, bus.score_p2}), 32'h09);

        // Short glitch, multi-bit press, then both wrong
        do_reset();
        hold_quiet("t4_glitch", 8'h7F, 3);
        hold_quiet("t4_multi", 8'h3F, 20);
        do_press("t4a", 8'hBF);
        check_val("t4a_res", 32'({last_res, last_rp}), 32'b1001);
        check_val("t4a_lock", 32'({bus.lock_p1, bus.lock_p2}), 2);
        do_press("t4b", 8'hFB);
        check_val("t4b_res", 32'({last_res, last_rp}), 32'b1010);
        check_val("t4b_q", 32'(bus.q_index), 1);
        check_val("t4b_lock", 32'({bus.lock_p1, bus.lock_p2}), 0);
        check_val("t4b_s", 32'({bus.score_p1, bus.score_p2}), 0);

        // Win, frozen game-over, restart
        do_reset();
        for (int k = 0; k < 5; k++) do_press("t5", 8'h7F);
        check_val("t5_over", 32'({bus.game_over, bus.beep}), 3);
        check_val("t5_s1", 32'(bus.score_p1), 5);
        check_val("t5_q", 32'(bus.q_index), 4);
        hold_quiet("t5_frozen", 8'h7F, 30);
        check_val("t5_s1_frozen", 32'(bus.score_p1), 5);
        check_val("t5_q_frozen", 32'(bus.q_index), 4);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check_val("t5_rs_s", 32'({bus.score_p1, bus.score_p2}), 0);
        check_val("t5_rs_q", 32'(bus.q_index), 0);
        check_val("t5_rs_over", 32'({bus.game_over, bus.beep}), 0);

        // Question wrap and asynchronous reset during SHOW
        do_reset();
        for (int k = 0; k < 9; k++) begin
            do_press("t6w1", 8'hBF);
            do_press("t6w2", 8'hFB);
        end
        check_val("t6_q9", 32'(bus.q_index), 9);
        do_press("t6c", 8'h7F);
        check_val("t6_wrap", 32'(bus.q_index), 0);
        check_val("t6_s1", 32'(bus.score_p1), 1);
        bus.joy_n = 8'h7F;
        for (int i = 0; i < 40 && bus.result == 2'b00; i++) @(negedge clk);
        check_val("t6_in_show", 32'(bus.result), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t6_ar_res", 32'({bus.result, bus.result_player}), 0);
        check_val("t6_ar_s", 32'({bus.score_p1, bus.score_p2}), 0);
        check_val("t6_ar_q", 32'(bus.q_index), 0);
        check_val("t6_ar_over", 32'({bus.game_over, bus.beep}), 0);
        bus.joy_n = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
